// File: rtl/waveform_capture.sv
// Waveform buffer writer: captures NSAMPLES ADC words on an armed trigger
// rise and freezes them with a wavenum until the readout signals done.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset_n      synchronous active-low reset
//   adc_data     ADC sample, valid every clock
//   trig         trigger level, rising edge used
//   arm          trigger rises accepted only while high
//   readout_done one-cycle pulse: buffer consumed
//   waveform     captured samples, index 0 oldest
//   wavenum      number of the waveform in the buffer
//   wave_ready   buffer holds a complete frozen waveform
//   busy         high in CAPTURE or READY
//   missed_trig  saturating count of armed rises not captured
module waveform_capture #(
    parameter int NSAMPLES  = 1000,
    parameter int ADC_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 trig,
    input  logic                 arm,
    input  logic                 readout_done,
    output logic [ADC_WIDTH-1:0] waveform [NSAMPLES],
    output logic [15:0]          wavenum,
    output logic                 wave_ready,
    output logic                 busy,
    output logic [15:0]          missed_trig
);

    localparam int IW = (NSAMPLES > 1) ? $clog2(NSAMPLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          trig_q;

    logic          trig_rise;
    logic          accept;
    logic          missed;
    logic          wr_en;
    logic [IW-1:0] wr_idx;

    assign trig_rise = trig & ~trig_q;
    assign accept    = (state == IDLE) & trig_rise & arm;
    assign missed    = (state != IDLE) & trig_rise & arm;

    // The accepting edge itself stores sample 0, so the write port is
    // open in IDLE for that one edge and for every CAPTURE edge.
    assign wr_en  = accept | (state == CAPTURE);
    assign wr_idx = (state == CAPTURE) ? idx : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            trig_q      <= 1'b0;
            wave_ready  <= 1'b0;
            busy        <= 1'b0;
            wavenum     <= '0;
            missed_trig <= '0;
        end else begin
            trig_q <= trig;

            if (missed && (missed_trig != 16'hFFFF)) begin
                missed_trig <= missed_trig + 16'd1;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        idx   <= IW'(1);
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (idx == LAST) begin
                        idx        <= '0;
                        wave_ready <= 1'b1;
                        wavenum    <= wavenum + 16'd1;
                        state      <= READY;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                READY: begin
                    if (readout_done) begin
                        wave_ready <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    idx        <= '0;
                    wave_ready <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Sample storage carries no reset; contents are undefined after reset.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            waveform[wr_idx] <= adc_data;
        end
    end

endmodule

// File: doc/waveform_capture.md
Name: waveform_capture

Overview:
Writer side of the waveform buffer. On an armed trigger it records NSAMPLES consecutive ADC words into a waveform array, then presents the array frozen together with a 16-bit waveform number. It holds the buffer until the downstream readout, which streams samples 1..NSAMPLES plus the waveform number, signals completion. It sits between the ADC data path and the sample readout / Ethernet packetiser.

Parameters:
NSAMPLES, 1000, samples per waveform (>=2); index width is clog2(NSAMPLES).
ADC_WIDTH, 14, ADC word width.

Ports:
clk  input  1  system clock; all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
adc_data  input  ADC_WIDTH  ADC sample, valid every clk.
trig  input  1  trigger level; the rising edge is used.
arm  input  1  level; trigger rises are accepted only while arm=1.
readout_done  input  1  one-cycle pulse from the readout: buffer consumed.
waveform  output  ADC_WIDTH x NSAMPLES (unpacked array)  captured samples; index 0 is the oldest.
wavenum  output  16  number of the waveform currently in the buffer.
wave_ready  output  1  high while the buffer holds a complete, frozen waveform.
busy  output  1  high in CAPTURE or READY.
missed_trig  output  16  count of armed trigger rises that were not captured.

Behaviour:
- Reset (reset_n=0 at a posedge) forces:
  - state=IDLE, idx=0, trig_q=0;
  - wave_ready=0, busy=0, wavenum=0, missed_trig=0;
  - waveform contents are not cleared and are undefined after reset.
- Reset wins over every other event, including reset in the middle of CAPTURE. That capture is abandoned and wavenum is not incremented.
- trig_rise = trig & ~trig_q, where trig_q is trig registered every cycle.
- IDLE:
  - If trig_rise & arm at edge k: waveform[0] <= adc_data sampled at edge k, idx <= 1, go to CAPTURE.
  - Otherwise stay in IDLE. A rise with arm=0 is ignored and not counted.
- CAPTURE:
  - At each edge: waveform[idx] <= adc_data, idx <= idx+1.
  - Sample i is therefore adc_data at edge k+i, for i = 0..NSAMPLES-1.
  - At the edge writing idx = NSAMPLES-1: wave_ready <= 1, wavenum <= wavenum+1 (wraps 65535 -> 0), idx <= 0, go to READY.
  - wave_ready and the new wavenum are both visible from edge k+NSAMPLES-1 onward. Capture latency from trigger edge to wave_ready is NSAMPLES-1 cycles.
  - Deasserting arm during CAPTURE does not abort the capture.
- READY:
  - waveform and wavenum are held constant.
  - On readout_done=1: wave_ready <= 0, go to IDLE. The next trigger can be accepted from the following edge.
- missed_trig:
  - Increments by 1 on trig_rise & arm while in CAPTURE or READY.
  - This includes a rise coinciding with readout_done in READY; that rise is missed, not captured.
  - Saturates at 65535.
- readout_done is ignored in IDLE and CAPTURE.
- busy = (state != IDLE), registered with the state.
- A trig held high gives exactly one rise and therefore at most one capture.
- The first capture after reset carries wavenum=1.

Test Plan:
1. Reset, arm=1, adc_data = free-running 14-bit counter. Pulse trig at edge k while adc_data=100 -> waveform[i] = 100+i for i = 0..999. wave_ready rises at edge k+999. wavenum=1, busy=1.
2. Continue from scenario 1 and give 3 trig rises while READY -> missed_trig=3 and the buffer is unchanged. Pulse readout_done -> wave_ready=0 and busy=0 the next cycle. Trigger again -> wavenum=2.
3. arm=0 with a trig rise in IDLE -> no capture, busy=0, missed_trig=0. Set arm=1 and hold trig high -> no capture until trig falls and rises again.
4. Assert reset_n=0 at idx=500 of a capture -> next cycle wave_ready=0, busy=0, wavenum=0. A fresh trigger then captures a full 1000 samples and gives wavenum=1.
5. In READY, readout_done and a trig rise in the same cycle -> state goes to IDLE, no capture starts, missed_trig increments by 1.
6. Force wavenum=65535 via 65535 capture cycles (or a NSAMPLES=2 build for speed) -> the next completed capture gives wavenum=0.
